// File: rtl/wakeup_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wakeup_ctrl
// Description : Sleep-request side of the core clock-gating handshake.
//               On a retired WFI it stalls fetch, waits for the pipeline to
//               drain and then requests clock gating through core_sleep_o.
//               An enabled interrupt drops the request, waits WAKE_DELAY
//               cycles for the core clock to restart, then releases fetch
//               with a one-cycle wake pulse carrying the wake cause.
//               Runs on the free-running (ungated) clock.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i          in   1      free-running clock
//   rst_n          in   1      asynchronous active-low reset
//   wfi_i          in   1      core retired WFI (1-cycle pulse)
//   pipe_empty_i   in   1      pipeline has no in-flight instructions
//   irq_i          in   N_IRQ  level interrupt requests
//   irq_mask_i     in   N_IRQ  1 = source may wake/abort sleep
//   core_sleep_o   out  1      request clock gating (to sleep unit)
//   stall_fetch_o  out  1      hold fetch stage
//   wake_valid_o   out  1      1-cycle pulse: core resumes after WFI
//   wake_cause_o   out  CW     index of waking irq
//   abort_o        out  1      1-cycle pulse: WFI abandoned
//   sleep_cnt_o    out  16     number of SLEEP entries, saturating
// ============================================================================
module wakeup_ctrl #(
  parameter int N_IRQ         = 8,
  parameter int WAKE_DELAY    = 4,
  parameter int DRAIN_TIMEOUT = 16,
  parameter int CW            = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             wfi_i,
  input  logic             pipe_empty_i,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic [N_IRQ-1:0] irq_mask_i,
  output logic             core_sleep_o,
  output logic             stall_fetch_o,
  output logic             wake_valid_o,
  output logic [CW-1:0]    wake_cause_o,
  output logic             abort_o,
  output logic [15:0]      sleep_cnt_o
);

  localparam int DCW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam int WCW = (WAKE_DELAY > 1) ? $clog2(WAKE_DELAY) : 1;

  localparam logic [DCW-1:0] c_drain_last = DCW'(DRAIN_TIMEOUT - 1);
  localparam logic [WCW-1:0] c_wake_init  = WCW'(WAKE_DELAY - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SLEEP = 2'd2,
    ST_WAKE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DCW-1:0]   r_drain_cnt;
  logic [DCW-1:0]   w_drain_cnt_nxt;
  logic [WCW-1:0]   r_wake_cnt;
  logic [WCW-1:0]   w_wake_cnt_nxt;

  logic             w_sleep_nxt;
  logic             w_stall_nxt;
  logic             w_wake_valid_nxt;
  logic             w_abort_nxt;
  logic [CW-1:0]    w_cause_nxt;
  logic [15:0]      w_sleep_cnt_nxt;

  logic [N_IRQ-1:0] w_irq_act;
  logic             w_pend;
  logic [CW-1:0]    w_lowest;

  assign w_irq_act = irq_i & irq_mask_i;
  assign w_pend    = |w_irq_act;

  // Lowest set index wins: scan from the top so lower indices overwrite.
  always_comb begin
    w_lowest = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_irq_act[i]) begin
        w_lowest = CW'(i);
      end
    end
  end

  // Next-state and next-output logic. Outputs are registered, so they are
  // derived from the state being entered rather than the current one.
  always_comb begin
    w_state_nxt      = r_state;
    w_drain_cnt_nxt  = r_drain_cnt;
    w_wake_cnt_nxt   = r_wake_cnt;
    w_cause_nxt      = wake_cause_o;
    w_sleep_cnt_nxt  = sleep_cnt_o;
    w_wake_valid_nxt = 1'b0;
    w_abort_nxt      = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (wfi_i) begin
          if (w_pend) begin
            // WFI with an interrupt already pending completes immediately.
            w_wake_valid_nxt = 1'b1;
            w_abort_nxt      = 1'b1;
            w_cause_nxt      = w_lowest;
          end else begin
            w_state_nxt     = ST_DRAIN;
            w_drain_cnt_nxt = '0;
          end
        end
      end

      ST_DRAIN: begin
        if (w_pend) begin
          w_state_nxt      = ST_RUN;
          w_wake_valid_nxt = 1'b1;
          w_abort_nxt      = 1'b1;
          w_cause_nxt      = w_lowest;
        end else if (pipe_empty_i) begin
          w_state_nxt = ST_SLEEP;
          if (sleep_cnt_o != 16'hFFFF) begin
            w_sleep_cnt_nxt = sleep_cnt_o + 16'd1;
          end
        end else if (r_drain_cnt == c_drain_last) begin
          // Pipeline never drained: give up without a wake event.
          w_state_nxt = ST_RUN;
          w_abort_nxt = 1'b1;
        end else begin
          w_drain_cnt_nxt = r_drain_cnt + 1'b1;
        end
      end

      ST_SLEEP: begin
        if (w_pend) begin
          w_state_nxt    = ST_WAKE;
          w_wake_cnt_nxt = c_wake_init;
          w_cause_nxt    = w_lowest;
        end
      end

      ST_WAKE: begin
        // Committed to waking: a dropped interrupt does not cancel this.
        if (r_wake_cnt == '0) begin
          w_state_nxt      = ST_RUN;
          w_wake_valid_nxt = 1'b1;
        end else begin
          w_wake_cnt_nxt = r_wake_cnt - 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase

    w_stall_nxt = (w_state_nxt != ST_RUN);
    w_sleep_nxt = (w_state_nxt == ST_SLEEP);
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_drain_cnt   <= '0;
      r_wake_cnt    <= '0;
      core_sleep_o  <= 1'b0;
      stall_fetch_o <= 1'b0;
      wake_valid_o  <= 1'b0;
      wake_cause_o  <= '0;
      abort_o       <= 1'b0;
      sleep_cnt_o   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_drain_cnt   <= w_drain_cnt_nxt;
      r_wake_cnt    <= w_wake_cnt_nxt;
      core_sleep_o  <= w_sleep_nxt;
      stall_fetch_o <= w_stall_nxt;
      wake_valid_o  <= w_wake_valid_nxt;
      wake_cause_o  <= w_cause_nxt;
      abort_o       <= w_abort_nxt;
      sleep_cnt_o   <= w_sleep_cnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wakeup_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wakeup_ctrl
// Description : Directed self-checking bench for wakeup_ctrl with default
//               parameters (N_IRQ=8, WAKE_DELAY=4, DRAIN_TIMEOUT=16).
//               Inputs change and outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wakeup_ctrl;

  logic        clk_i;
  logic        rst_n;
  logic        wfi_i;
  logic        pipe_empty_i;
  logic [7:0]  irq_i;
  logic [7:0]  irq_mask_i;
  logic        core_sleep_o;
  logic        stall_fetch_o;
  logic        wake_valid_o;
  logic [2:0]  wake_cause_o;
  logic        abort_o;
  logic [15:0] sleep_cnt_o;

  int n_checks;
  int n_errors;

  wakeup_ctrl #(
    .N_IRQ        (8),
    .WAKE_DELAY   (4),
    .DRAIN_TIMEOUT(16)
  ) u_dut (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .wfi_i        (wfi_i),
    .pipe_empty_i (pipe_empty_i),
    .irq_i        (irq_i),
    .irq_mask_i   (irq_mask_i),
    .core_sleep_o (core_sleep_o),
    .stall_fetch_o(stall_fetch_o),
    .wake_valid_o (wake_valid_o),
    .wake_cause_o (wake_cause_o),
    .abort_o      (abort_o),
    .sleep_cnt_o  (sleep_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Snapshot of every output at once, compared against hand-computed values.
  task automatic chk_all(input string tag, input logic sleep, input logic stall,
                         input logic valid, input logic abrt, input logic [15:0] cnt);
    chk({tag, ".sleep"}, 32'(core_sleep_o), 32'(sleep));
    chk({tag, ".stall"}, 32'(stall_fetch_o), 32'(stall));
    chk({tag, ".valid"}, 32'(wake_valid_o), 32'(valid));
    chk({tag, ".abort"}, 32'(abort_o), 32'(abrt));
    chk({tag, ".cnt"},   32'(sleep_cnt_o), 32'(cnt));
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst_n        = 1'b0;
    wfi_i        = 1'b0;
    pipe_empty_i = 1'b0;
    irq_i        = 8'h00;
    irq_mask_i   = 8'hFF;

    // Reset state
    step(); step();
    chk_all("reset", 0, 0, 0, 0, 16'd0);
    chk("reset.cause", 32'(wake_cause_o), 32'd0);
    rst_n = 1'b1;
    step();
    chk_all("idle", 0, 0, 0, 0, 16'd0);

    // Normal entry/exit, pipe drains two cycles after the WFI
    wfi_i = 1'b1;
    step();
    wfi_i = 1'b0;
    chk_all("drain0", 0, 1, 0, 0, 16'd0);
    step();
    chk_all("drain1", 0, 1, 0, 0, 16'd0);
    pipe_empty_i = 1'b1;
    step();
    pipe_empty_i = 1'b0;
    chk_all("sleep", 1, 1, 0, 0, 16'd1);
    step();
    chk_all("sleep_hold", 1, 1, 0, 0, 16'd1);
    irq_i = 8'h20;
    step();
    chk_all("wake0", 0, 1, 0, 0, 16'd1);
    irq_i = 8'h00;  // dropping the irq must not cancel the wakeup
    for (int i = 1; i <= 3; i++) begin
      step();
      chk_all("wake_wait", 0, 1, 0, 0, 16'd1);
    end
    step();
    chk_all("woke", 0, 0, 1, 0, 16'd1);
    chk("woke.cause", 32'(wake_cause_o), 32'd5);
    step();
    chk_all("woke_after", 0, 0, 0, 0, 16'd1);

    // Masked irq keeps the core asleep; an enabled one wakes it
    wfi_i = 1'b1;
    step();
    wfi_i = 1'b0;
    pipe_empty_i = 1'b1;
    step();
    pipe_empty_i = 1'b0;
    chk_all("m_sleep", 1, 1, 0, 0, 16'd2);
    irq_i      = 8'h01;
    irq_mask_i = 8'hFE;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("m_masked", 1, 1, 0, 0, 16'd2);
    end
    irq_i = 8'h81;
    step();
    chk_all("m_wake0", 0, 1, 0, 0, 16'd2);
    irq_i = 8'h00;
    step(); step(); step();
    chk_all("m_wake3", 0, 1, 0, 0, 16'd2);
    step();
    chk_all("m_woke", 0, 0, 1, 0, 16'd2);
    chk("m_woke.cause", 32'(wake_cause_o), 32'd7);

    // Reset mid-SLEEP
    irq_mask_i = 8'hFF;
    wfi_i = 1'b1;
    step();
    wfi_i = 1'b0;
    pipe_empty_i = 1'b1;
    step();
    pipe_empty_i = 1'b0;
    chk_all("r_sleep", 1, 1, 0, 0, 16'd3);
    rst_n = 1'b0;
    step();
    chk_all("r_reset", 0, 0, 0, 0, 16'd0);
    rst_n = 1'b1;
    step();
    chk_all("r_after", 0, 0, 0, 0, 16'd0);

    // WFI with an interrupt already pending
    irq_i = 8'h0C;
    wfi_i = 1'b1;
    step();
    wfi_i = 1'b0;
    chk_all("p_wfi", 0, 0, 1, 1, 16'd0);
    chk("p_wfi.cause", 32'(wake_cause_o), 32'd2);
    irq_i = 8'h00;
    step();
    chk_all("p_after", 0, 0, 0, 0, 16'd0);

    // Drain timeout: 16 cycles in DRAIN, then abort only
    wfi_i = 1'b1;
    step();
    wfi_i = 1'b0;
    chk_all("t_drain0", 0, 1, 0, 0, 16'd0);
    for (int i = 1; i <= 15; i++) begin
      step();
      chk_all("t_drain", 0, 1, 0, 0, 16'd0);
    end
    step();
    chk_all("t_abort", 0, 0, 0, 1, 16'd0);
    chk("t_abort.cause", 32'(wake_cause_o), 32'd2);
    step();
    chk_all("t_after", 0, 0, 0, 0, 16'd0);

    // DRAIN: irq and pipe_empty together, irq wins
    wfi_i = 1'b1;
    step();
    wfi_i = 1'b0;
    chk_all("x_drain", 0, 1, 0, 0, 16'd0);
    pipe_empty_i = 1'b1;
    irq_i        = 8'h02;
    step();
    pipe_empty_i = 1'b0;
    irq_i        = 8'h00;
    chk_all("x_irq", 0, 0, 1, 1, 16'd0);
    chk("x_irq.cause", 32'(wake_cause_o), 32'd1);
    step();
    chk_all("x_after", 0, 0, 0, 0, 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
